// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: character width and the
// transmit-buffer control FSM encoding.
package uart_pkg;

    localparam int UART_CW = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a flush that empties it at the
// next edge. DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [AW:0]  cnt,
    output logic         empty,
    output logic         full
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guarding here as well keeps cnt in 0..DEPTH whatever the caller does.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign rdata = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; a slot is always
    // written before cnt lets anyone read it, so resetting it buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Character buffer in front of a UART transmitter: queues upstream characters
// and hands them out one at a time, waiting for tx_done between frames.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = UART_CW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [CW-1:0]            in_ch,
    output logic                     tx_ch_vld,
    output logic [CW-1:0]            tx_ch,
    input  logic                     tx_done,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     empty,
    output logic                     full,
    output logic                     busy
);

    tx_state_e     state;
    tx_state_e     state_nxt;
    logic          pop;
    logic [CW-1:0] fifo_rdata;

    assign in_rdy = ~full;
    assign busy   = (state == S_WAIT);

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_vld & in_rdy),
        .pop   (pop),
        .flush (flush),
        .wdata (in_ch),
        .rdata (fifo_rdata),
        .cnt   (cnt),
        .empty (empty),
        .full  (full)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                // A flush wins over a pop: nothing is started from a buffer
                // that is being emptied this very edge.
                if (!empty && !flush) begin
                    pop       = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tx_ch_vld <= 1'b0;
            tx_ch     <= '0;
        end else begin
            state     <= state_nxt;
            tx_ch_vld <= pop;
            if (pop) begin
                tx_ch <= fifo_rdata;
            end
        end
    end

endmodule
